// File: rtl/irrigation_countdown_ctrl.sv
// MM:SS BCD countdown sequencer for one irrigation zone.
// Loads a preset, counts down on a 1 Hz tick and drives the valve while running.
module irrigation_countdown_ctrl #(
    parameter logic [3:0] SEC_TENS_MAX = 4'd5,
    parameter logic [3:0] MIN_TENS_MAX = 4'd9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    output logic [15:0] digits,
    output logic        valve,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUNNING,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] digits_q;
    logic        valve_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic [15:0] digits_dec;
    logic        preset_ok;
    logic        is_last_second;
    logic        load_act;
    logic        pause_act;
    logic        start_act;
    logic        tick_act;

    // Decade-down chain: each digit wraps to its maximum and borrows onward.
    always_comb begin
        logic       b0;
        logic       b1;
        logic       b2;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        digits_dec = digits_q;
        b0 = (digits_q[3:0] == 4'd0);
        b1 = b0 && (digits_q[7:4] == 4'd0);
        b2 = b1 && (digits_q[11:8] == 4'd0);
        digits_dec[3:0] = b0 ? 4'd9 : digits_q[3:0] - 4'd1;
        if (b0) digits_dec[7:4]   = (digits_q[7:4] == 4'd0) ? SEC_TENS_MAX : digits_q[7:4] - 4'd1;
        if (b1) digits_dec[11:8]  = (digits_q[11:8] == 4'd0) ? 4'd9 : digits_q[11:8] - 4'd1;
        if (b2) digits_dec[15:12] = digits_q[15:12] - 4'd1;
    end

    assign preset_ok = (preset[3:0] <= 4'd9) && (preset[7:4] <= 4'd9) &&
                       (preset[11:8] <= 4'd9) && (preset[15:12] <= 4'd9) &&
                       (preset[7:4] <= SEC_TENS_MAX) && (preset[15:12] <= MIN_TENS_MAX);
    assign is_last_second = (digits_q == 16'h0001);

    // A request ignored in the current state does not mask lower-priority ones.
    assign load_act  = load && (state_q != S_RUNNING);
    assign pause_act = pause && (state_q == S_RUNNING);
    assign start_act = start && ((state_q == S_ARMED) || (state_q == S_PAUSED));
    assign tick_act  = tick && (state_q == S_RUNNING);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            digits_q <= 16'h0000;
            valve_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (abort) begin
                state_q  <= S_IDLE;
                digits_q <= 16'h0000;
                valve_q  <= 1'b0;
                busy_q   <= 1'b0;
            end else if (load_act) begin
                if (preset_ok) begin
                    state_q  <= S_ARMED;
                    digits_q <= preset;
                    valve_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end else begin
                    error_q <= 1'b1;
                end
            end else if (pause_act) begin
                state_q <= S_PAUSED;
                valve_q <= 1'b0;
            end else if (start_act) begin
                if (state_q == S_ARMED && digits_q == 16'h0000) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_RUNNING;
                    valve_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
            end else if (tick_act) begin
                digits_q <= digits_dec;
                if (is_last_second) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    valve_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign digits = digits_q;
    assign valve  = valve_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule

// File: doc/irrigation_countdown_ctrl.md
Name: irrigation_countdown_ctrl

Overview:
- Sequences a 4-digit BCD MM:SS countdown for one irrigation zone.
- Loads a preset duration, decrements on a 1 Hz tick enable with borrow cascading across digits, and drives the valve while the count is running.
- Sits between the operator/keypad front end and the valve driver. The digit chain uses the same decade-down discipline as the existing down-from-9 digit counters, with 0 wrapping to 9 and a borrow passed onward.

Parameters:
SEC_TENS_MAX, 5, upper bound of seconds-tens digit; wraps 0 -> SEC_TENS_MAX on borrow
MIN_TENS_MAX, 9, upper bound of minutes-tens digit; a preset above this is rejected

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; clears all state immediately
tick  input  1  1-cycle count enable (1 Hz strobe from prescaler)
load  input  1  1-cycle request to load preset
preset  input  16  BCD {min_tens, min_units, sec_tens, sec_units}
start  input  1  1-cycle request to start/resume countdown
pause  input  1  1-cycle request to pause countdown
abort  input  1  1-cycle request to cancel and clear
digits  output  16  current count, same BCD layout as preset
valve  output  1  high exactly while state = RUNNING
busy  output  1  high in RUNNING or PAUSED
done  output  1  1-cycle pulse when the count expires
error  output  1  1-cycle pulse on a rejected load

Behaviour:
- Single clock domain, one clock.
- Reset is asynchronous and active-low. While reset is low: state = IDLE, digits = 0x0000, valve = busy = done = error = 0.
- All outputs are registered.
- FSM states: IDLE, ARMED, RUNNING, PAUSED, DONE.
- Request priority, checked each cycle: abort > load > pause > start > tick.
- abort, any state: next state IDLE, digits := 0, valve drops the next cycle, no done pulse.
- load, accepted in IDLE, ARMED, PAUSED and DONE; ignored in RUNNING.
  - Preset is valid only if every digit <= 9, sec_tens <= SEC_TENS_MAX and min_tens <= MIN_TENS_MAX.
  - Valid preset: digits := preset, next state ARMED.
  - Invalid preset: digits and state unchanged, error = 1 for one cycle.
- start:
  - ARMED with digits != 0: go to RUNNING.
  - ARMED with digits = 0: go to DONE, done pulses, valve never asserts.
  - PAUSED: return to RUNNING.
  - Ignored in IDLE, RUNNING and DONE.
- pause: RUNNING -> PAUSED. Ignored elsewhere.
- tick in RUNNING, with no higher-priority request that cycle: decrement by one second.
  - sec_units 0 -> 9 with borrow; sec_tens 0 -> SEC_TENS_MAX with borrow; min_units 0 -> 9 with borrow; min_tens decrements on borrow.
  - Digits update on the edge after tick (latency 1).
  - Ticks in any other state are ignored.
- Expiry: a tick that moves digits from 0x0001 to 0x0000 also sets next state DONE and asserts done for that one cycle (same edge digits read 0000). valve is low from that edge onward.
- Same-cycle collisions:
  - start+tick in ARMED: start only; first decrement on the next tick.
  - pause+tick in RUNNING: pause wins, no decrement.
  - load+start: load wins, start dropped.
- DONE holds digits at 0x0000 until load or abort.
- The count never underflows below 0000. A 99:59 preset is legal: 5999 ticks to expiry.
- Reset asserted mid-RUNNING: valve drops asynchronously and everything returns to the reset values.

Test Plan:
- Reset low mid-run at 01:30 -> digits 0000, valve 0, state IDLE immediately (before the next clock edge).
- load preset 0x0103, start, 4 ticks -> digits step 0102, 0101, 0100, 0059. valve = 1 throughout, done = 0.
- load 0x0002, start, 2 ticks -> digits 0001 then 0000. done pulses one cycle on the second tick's edge, valve falls the same edge, state DONE.
- load 0x0070 -> error pulse, digits unchanged. load 0x0A00 -> error pulse. load 0x0000 then start -> done pulse, valve never 1.
- Running at 0x0010: pause+tick same cycle -> digits stay 0010, valve 0. Extra ticks -> no change. start -> valve 1, next tick gives 0009.
- Running at 0x0500: load during RUNNING ignored; abort+tick same cycle -> digits 0000, state IDLE, no done pulse.
